l1_wt_cache: RTL

- Direct-mapped, write-through, no-write-allocate L1 cache, one instance per core.
- Sits directly upstream of mem_arbiter: its memory-side port is one cache2arb[i] requester slot in mp_system.
- Accepts single-word core loads/stores, serves read hits locally and forwards misses and all stores to memory.
- One outstanding request at a time.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/l1_tag_data_array.sv | 54 +++++
 rtl/l1_wt_cache.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and sizing for the L1 write-through cache slice.
//   - CACHE_* localparams: default geometry (16-bit word address, 32-bit data,
//     64 one-word lines) with derived index/tag widths.
//   - cache_state_e: controller state encoding.
//   - cache_req_t: request registered when the core handshake completes.
// Optional feature macro used by the slice: L1_CACHE_STATS_EN.
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int CACHE_ADDR_W  = 16;
   localparam int CACHE_DATA_W  = 32;
   localparam int CACHE_SETS    = 64;
   localparam int CACHE_INDEX_W = $clog2(CACHE_SETS);
   localparam int CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      RESP   = 3'd4
   } cache_state_e;

   typedef struct packed {
      logic                    we;
      logic [CACHE_ADDR_W-1:0] addr;
      logic [CACHE_DATA_W-1:0] wdata;
   } cache_req_t;

endpackage

// File: rtl/l1_tag_data_array.sv
// -----------------------------------------------------------------------------
// l1_tag_data_array
// Valid bits, tag array and data array for a direct-mapped one-word-per-line
// cache.
//   clk, reset        : system clock, synchronous active-high reset (valids only)
//   rd_idx            : combinational read index
//   rd_valid/tag/data : contents of line rd_idx
//   wr_en, wr_idx     : synchronous write of tag+data, sets the line valid
//   wr_tag, wr_data   : write payload (fill or store hit)
// -----------------------------------------------------------------------------
module l1_tag_data_array
   import cache_pkg::*;
#(
   parameter int SETS    = CACHE_SETS,
   parameter int INDEX_W = CACHE_INDEX_W,
   parameter int TAG_W   = CACHE_TAG_W,
   parameter int DATA_W  = CACHE_DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data
);

   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [DATA_W-1:0] data_mem [SETS];

   always_ff @(posedge clk) begin
      if (reset)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Tag/data storage carries no reset; only valid bits qualify its contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/l1_wt_cache.sv
// -----------------------------------------------------------------------------
// l1_wt_cache
// Direct-mapped, write-through, no-write-allocate L1 cache; one outstanding
// request. Load hits are served locally, load misses and every store go to
// the memory arbiter port.
//   clk, reset                 : system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      : core request, accepted when cpu_ready
//   cpu_ready                  : high in IDLE only
//   cpu_resp_valid, cpu_rdata  : one-cycle completion pulse with load data
//   mem_req/we/addr/wdata      : registered memory request, held until mem_ack
//   mem_ack, mem_rdata         : grant/completion, read data valid with ack
//   stat_hits/misses/stores    : saturating counters, only with
//                                L1_CACHE_STATS_EN defined
//
// state  | meaning
// IDLE   | ready for a core request
// LOOKUP | compare tag of registered request, update data on store hit
// MEM_RD | load miss outstanding at memory, fill on ack
// MEM_WR | store write-through outstanding at memory
// RESP   | cpu_resp_valid pulse
// -----------------------------------------------------------------------------
module l1_wt_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W = CACHE_ADDR_W,
   parameter int DATA_W = CACHE_DATA_W,
   parameter int SETS   = CACHE_SETS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_resp_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef L1_CACHE_STATS_EN
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses,
   output logic [31:0]       stat_stores,
`endif
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = ADDR_W - INDEX_W;

   cache_state_e      state;
   cache_req_t        req;
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic              hit;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;

   assign req_idx = req.addr[INDEX_W-1:0];
   assign req_tag = req.addr[ADDR_W-1:INDEX_W];
   assign hit     = rd_valid && (rd_tag == req_tag);

   // Single write port: store hit in LOOKUP, or fill on read ack. A store hit
   // rewrites the same tag and keeps the line valid, so one port serves both.
   assign wr_en   = ((state == LOOKUP) && req.we && hit) ||
                    ((state == MEM_RD) && mem_ack);
   assign wr_data = (state == MEM_RD) ? mem_rdata : req.wdata;

   assign cpu_ready      = (state == IDLE);
   assign cpu_resp_valid = (state == RESP);

   l1_tag_data_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (req_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req       <= '0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  req   <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                  state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (req.we) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= req.addr;
                  mem_wdata <= req.wdata;
                  state     <= MEM_WR;
               end else if (hit) begin
                  cpu_rdata <= rd_data;
                  state     <= RESP;
               end else begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= req.addr;
                  state    <= MEM_RD;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  cpu_rdata <= mem_rdata;
                  state     <= RESP;
               end
            end
            MEM_WR: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef L1_CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_stores <= '0;
      end else if (state == LOOKUP) begin
         if (req.we) begin
            if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
         end else if (hit) begin
            if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
         end else begin
            if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
         end
      end
   end
`endif

endmodule
